// File: rtl/serial_add_sched_pkg.sv
// Shared types and helpers for the serial-adder scheduler.
package serial_add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int NREQ_DEF = 2;
  localparam int W_DEF    = 8;

  // Index width for a requester id; never narrower than one bit.
  function automatic int idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/serial_add_scheduler_arb.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping.
module rr_arbiter_onehot
  import serial_add_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = idw(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int  j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end else begin
        j = j;
      end
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = IDW'(j);
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/serial_add_scheduler.sv
// Shares one bit-serial adder among NREQ parallel-operand requesters.
// Optional macro SERADD_SCHED_OVF_EN adds rsp_ovf (carry out of the MSB).
module serial_add_scheduler
  import serial_add_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  localparam int IDW = idw(NREQ),
  localparam int CW  = $clog2(W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_rdy,
  output logic              add_vld,
  output logic              add_a,
  output logic              add_b,
  output logic              add_last,
  input  logic              add_sum,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [IDW-1:0]    rsp_id,
`ifdef SERADD_SCHED_OVF_EN
  output logic              rsp_ovf,
`endif
  output logic [W-1:0]      rsp_sum
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [NREQ-1:0] gnt_s;
  logic [IDW-1:0]  gnt_idx_s;
  logic            gnt_any_s;
  logic            last_s;
`ifdef SERADD_SCHED_OVF_EN
  logic carry_q, carry_d;
`endif

  rr_arbiter_onehot #(.NREQ(NREQ)) u_arb (
    .req_i (req_vld),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (gnt_idx_s),
    .any_o (gnt_any_s)
  );

  assign last_s = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      sum_q   <= '0;
`ifdef SERADD_SCHED_OVF_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
`ifdef SERADD_SCHED_OVF_EN
      carry_q <= carry_d;
`endif
    end
  end

  // Next state and datapath: latch operands on grant, collect sum bits in SHIFT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    sum_d   = sum_q;
`ifdef SERADD_SCHED_OVF_EN
    carry_d = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any_s) begin
          state_d = SHIFT;
          cnt_d   = '0;
          a_d     = req_a[int'(gnt_idx_s)*W +: W];
          b_d     = req_b[int'(gnt_idx_s)*W +: W];
          id_d    = gnt_idx_s;
          sum_d   = '0;
`ifdef SERADD_SCHED_OVF_EN
          carry_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sum_d[cnt_q] = add_sum;
`ifdef SERADD_SCHED_OVF_EN
        carry_d = (a_q[cnt_q] & b_q[cnt_q]) | (carry_q & (a_q[cnt_q] ^ b_q[cnt_q]));
`endif
        if (last_s) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          state_d = IDLE;
          ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and serial-adder outputs decoded from the current state.
  always_comb begin
    req_rdy  = '0;
    add_vld  = 1'b0;
    add_a    = 1'b0;
    add_b    = 1'b0;
    add_last = 1'b0;
    rsp_vld  = 1'b0;
    case (state_q)
      IDLE: begin
        req_rdy = rst ? '0 : gnt_s;
      end
      SHIFT: begin
        add_vld  = 1'b1;
        add_a    = a_q[cnt_q];
        add_b    = b_q[cnt_q];
        add_last = last_s;
      end
      RESP: begin
        rsp_vld = 1'b1;
      end
      default: begin
        req_rdy = '0;
      end
    endcase
  end

  assign rsp_id  = id_q;
  assign rsp_sum = sum_q;
`ifdef SERADD_SCHED_OVF_EN
  assign rsp_ovf = carry_q;
`endif

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed + random bench for serial_add_scheduler with a serial-adder model and scoreboard.
module tb_serial_add_scheduler;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_vld = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_rdy;
  logic              add_vld, add_a, add_b, add_last, add_sum;
  logic              rsp_vld;
  logic              rsp_rdy = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_ovf_s;
  logic              carry_m;

  serial_add_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_rdy  (req_rdy),
    .add_vld  (add_vld),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_last (add_last),
    .add_sum  (add_sum),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_id   (rsp_id),
`ifdef SERADD_SCHED_OVF_EN
    .rsp_ovf  (rsp_ovf_s),
`endif
    .rsp_sum  (rsp_sum)
  );

`ifndef SERADD_SCHED_OVF_EN
  assign rsp_ovf_s = 1'b0;
`endif

  always #5 clk = ~clk;

  // External bit-serial adder: sum is combinational, carry held and cleared after last.
  assign add_sum = add_vld & (add_a ^ add_b ^ carry_m);
  always @(posedge clk) begin
    if (rst) carry_m <= 1'b0;
    else if (add_vld) carry_m <= add_last ? 1'b0 : ((add_a & add_b) | (carry_m & (add_a ^ add_b)));
  end

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           ovf;
  } rsp_t;

  rsp_t            sb[$];
  rsp_t            log_q[$];
  int              checks = 0;
  int              failures = 0;
  logic [NREQ-1:0] acc = '0;
  int              exp_shift = 0;
  bit              refill = 1'b0;
  int              issued = 0;
  int              target = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i);
    req_a[i*W +: W] = W'($urandom);
    req_b[i*W +: W] = W'($urandom);
  endtask

  // Scoreboard, add_vld window model and response log, sampled at negedge.
  task automatic monitor();
    rsp_t e, o;
    logic [W:0] s;
    if (rst) begin
      sb.delete();
      exp_shift = 0;
      acc = '0;
    end else begin
      chk("add_vld_window", 32'(add_vld), 32'(exp_shift > 0));
      chk("add_last_pos", 32'(add_last), 32'(exp_shift == 1));
      if (exp_shift > 0) exp_shift--;
      acc = req_rdy & req_vld;
      if (req_rdy != '0) begin
        chk("req_rdy_onehot", 32'($countones(req_rdy)), 32'd1);
        e.id = '0; e.sum = '0; e.ovf = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          if (req_rdy[i]) begin
            s     = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]};
            e.id  = IDW'(i);
            e.sum = s[W-1:0];
            e.ovf = s[W];
          end
        end
        if (acc != '0) begin
          sb.push_back(e);
          exp_shift = W;
        end
      end
      if (rsp_vld && rsp_rdy) begin
        o.id = rsp_id; o.sum = rsp_sum; o.ovf = rsp_ovf_s;
        log_q.push_back(o);
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_id", 32'(rsp_id), 32'(e.id));
          chk("sb_sum", 32'(rsp_sum), 32'(e.sum));
`ifdef SERADD_SCHED_OVF_EN
          chk("sb_ovf", 32'(rsp_ovf_s), 32'(e.ovf));
`endif
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        if (refill && issued < target) begin
          load(i);
          issued++;
        end else begin
          req_vld[i] = 1'b0;
        end
      end
    end
    if (refill) rsp_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic cyc();
    step();
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_rdy"}, 32'(req_rdy), 32'd0);
    chk({tag, "_add"}, 32'({add_vld, add_a, add_b, add_last}), 32'd0);
    chk({tag, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_sum"}, 32'(rsp_sum), 32'd0);
    chk({tag, "_rsp_ovf"}, 32'(rsp_ovf_s), 32'd0);
  endtask

  task automatic do_reset();
    step(); rst = 1'b1; req_vld = '0; rsp_rdy = 1'b1; tick();
    step(); tick();
    chk_zero("reset");
    step(); rst = 1'b0; tick();
  endtask

  task automatic wait_grant(input int i);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (acc[i]) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk("grant_seen", 32'(ok), 32'd1);
  endtask

  // From the grant cycle: W serial cycles with the right bits, then rsp in cycle W+1.
  task automatic check_timing(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] sum, input logic [IDW-1:0] id);
    for (int k = 1; k <= W; k++) begin
      cyc();
      chk("shift_vld", 32'(add_vld), 32'd1);
      chk("shift_last", 32'(add_last), 32'(k == W));
      chk("shift_bits", 32'({add_a, add_b}), 32'({a[k-1], b[k-1]}));
      chk("shift_no_rdy", 32'(req_rdy), 32'd0);
    end
    cyc();
    chk("rsp_vld_lat", 32'(rsp_vld), 32'd1);
    chk("rsp_sum_val", 32'(rsp_sum), 32'(sum));
    chk("rsp_id_val", 32'(rsp_id), 32'(id));
  endtask

  initial begin
    int base;

    // Test 1: single request, exact latency and serial stream.
    do_reset();
    step(); req_a[0 +: W] = 8'h35; req_b[0 +: W] = 8'h4A; req_vld[0] = 1'b1; tick();
    wait_grant(0);
    check_timing(8'h35, 8'h4A, 8'h7F, 1'b0);
    cyc();
    chk("t1_idle_after", 32'({rsp_vld, add_vld}), 32'd0);

    // Test 2: both requesters after reset; req0 first, then wrapping req1.
    do_reset();
    base = log_q.size();
    step();
    req_a = {8'hFF, 8'h10}; req_b = {8'h01, 8'h20}; req_vld = 2'b11;
    tick();
    for (int k = 0; k < 60 && log_q.size() < base + 2; k++) cyc();
    chk("t2_count", 32'(log_q.size()), 32'(base + 2));
    if (log_q.size() >= base + 2) begin
      chk("t2_first_id", 32'(log_q[base].id), 32'd0);
      chk("t2_first_sum", 32'(log_q[base].sum), 32'h30);
      chk("t2_second_id", 32'(log_q[base+1].id), 32'd1);
      chk("t2_second_sum", 32'(log_q[base+1].sum), 32'h00);
`ifdef SERADD_SCHED_OVF_EN
      chk("t2_second_ovf", 32'(log_q[base+1].ovf), 32'd1);
`endif
    end

    // Test 3: response stalled five cycles with another request pending.
    do_reset();
    base = log_q.size();
    step();
    rsp_rdy = 1'b0;
    req_a = {8'h01, 8'h11}; req_b = {8'h02, 8'h22}; req_vld = 2'b11;
    tick();
    for (int k = 0; k < 40 && !rsp_vld; k++) cyc();
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall_vld", 32'(rsp_vld), 32'd1);
      chk("t3_stall_sum", 32'(rsp_sum), 32'h33);
      chk("t3_stall_id", 32'(rsp_id), 32'd0);
      chk("t3_stall_add", 32'(add_vld), 32'd0);
      chk("t3_stall_rdy", 32'(req_rdy), 32'd0);
      cyc();
    end
    chk("t3_no_early_rsp", 32'(log_q.size()), 32'(base));
    step(); rsp_rdy = 1'b1; tick();
    cyc();
    chk("t3_next_grant", 32'(req_rdy), 32'b10);
    for (int k = 0; k < 40 && log_q.size() < base + 2; k++) cyc();
    chk("t3_count", 32'(log_q.size()), 32'(base + 2));
    if (log_q.size() >= base + 2) begin
      chk("t3_second_id", 32'(log_q[base+1].id), 32'd1);
      chk("t3_second_sum", 32'(log_q[base+1].sum), 32'h03);
    end

    // Test 4: reset in the 4th SHIFT cycle, then full rerun.
    do_reset();
    base = log_q.size();
    step(); req_a[W +: W] = 8'h0F; req_b[W +: W] = 8'h01; req_vld[1] = 1'b1; tick();
    wait_grant(1);
    step(); req_vld[1] = 1'b1; tick();
    cyc();
    cyc();
    step(); rst = 1'b1; tick();
    step(); tick();
    chk_zero("t4_mid_reset");
    step(); rst = 1'b0; tick();
    wait_grant(1);
    check_timing(8'h0F, 8'h01, 8'h10, 1'b1);
    cyc();
    chk("t4_one_rsp", 32'(log_q.size()), 32'(base + 1));

    // Test 5: both always valid, strict alternation.
    do_reset();
    base = log_q.size();
    step();
    refill = 1'b1; target = 4; issued = 2;
    load(0); load(1); req_vld = 2'b11;
    tick();
    for (int k = 0; k < 300 && log_q.size() < base + 4; k++) cyc();
    chk("t5_count", 32'(log_q.size()), 32'(base + 4));
    for (int k = 0; k < 4 && base + k < log_q.size(); k++)
      chk("t5_id_seq", 32'(log_q[base+k].id), 32'(k % 2));

    // Test 6: random operands and backpressure, 200 transactions.
    refill = 1'b0;
    do_reset();
    base = log_q.size();
    step();
    refill = 1'b1; target = 200; issued = 2;
    load(0); load(1); req_vld = 2'b11;
    tick();
    for (int k = 0; k < 20000 && log_q.size() < base + 200; k++) cyc();
    refill = 1'b0;
    step(); rsp_rdy = 1'b1; tick();
    for (int k = 0; k < 40 && sb.size() != 0; k++) cyc();
    chk("t6_count", 32'(log_q.size() >= base + 200), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
